frame_fifo_read_multi: RTL and testbench

Parametrised next-generation frame reader. It sits between a data-consumer module and the external memory controller burst-read interface, in the mem_clk domain. It issues burst reads for a frame selected from NUM_ADDR base addresses and keeps a downstream FIFO topped up. New over the previous generation: the last burst is truncated to the remaining length, a loop (circular playback) mode, a synchronous stop request, a zero-length frame guard, and busy/loop-count status.

---
 rtl/frame_fifo_read_multi.sv | 256 +++++++++++++++++++++++++
 tb/tb_frame_fifo_read_multi.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fifo_read_multi.sv
// frame_fifo_read_multi: multi-slot frame reader for the mem_clk domain.
// Issues burst reads for a frame chosen from NUM_ADDR base addresses and
// keeps the downstream FIFO topped up. The last burst is trimmed to the
// remaining length. Optional circular playback, a stop request and a guard
// for zero-length frames are included.
module frame_fifo_read_multi #(
    parameter int ADDR_BITS  = 23,
    parameter int BURST_BITS = 10,
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_SIZE = 128,
    parameter int NUM_ADDR   = 4,
    parameter int IDX_BITS   = 2
) (
    input  logic                          mem_clk,
    input  logic                          rst,
    output logic                          rd_burst_req,
    output logic [BURST_BITS-1:0]         rd_burst_len,
    output logic [ADDR_BITS-1:0]          rd_burst_addr,
    input  logic                          rd_burst_data_valid,
    input  logic                          rd_burst_finish,
    input  logic                          read_req,
    output logic                          read_req_ack,
    output logic                          read_finish,
    input  logic [NUM_ADDR*ADDR_BITS-1:0] read_addr_flat,
    input  logic [IDX_BITS-1:0]           read_addr_index,
    input  logic [ADDR_BITS-1:0]          read_len,
    input  logic                          loop_en,
    input  logic                          stop_req,
    output logic                          fifo_aclr,
    input  logic [15:0]                   wrusedw,
    output logic                          busy,
    output logic [15:0]                   loop_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACK       = 3'd1;
    localparam logic [2:0] S_CHECK     = 3'd2;
    localparam logic [2:0] S_BURST     = 3'd3;
    localparam logic [2:0] S_BURST_END = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;

    localparam logic [ADDR_BITS-1:0] BURST_SIZE_A = ADDR_BITS'(BURST_SIZE);
    localparam logic [16:0]          FIFO_DEPTH_W = 17'(FIFO_DEPTH);

    // Synchroniser chains
    logic [2:0]           req_sync_q,  req_sync_d;
    logic [2:0]           stop_sync_q, stop_sync_d;
    logic [ADDR_BITS-1:0] len_meta_q,  len_meta_d;
    logic [ADDR_BITS-1:0] len_s_q,     len_s_d;
    logic [IDX_BITS-1:0]  idx_meta_q,  idx_meta_d;
    logic [IDX_BITS-1:0]  idx_s_q,     idx_s_d;

    // Control state
    logic [2:0]            state_q,         state_d;
    logic [ADDR_BITS-1:0]  base_addr_q,     base_addr_d;
    logic [ADDR_BITS-1:0]  len_lat_q,       len_lat_d;
    logic [ADDR_BITS-1:0]  read_cnt_q,      read_cnt_d;
    logic                  rd_burst_req_q,  rd_burst_req_d;
    logic [BURST_BITS-1:0] rd_burst_len_q,  rd_burst_len_d;
    logic [ADDR_BITS-1:0]  rd_burst_addr_q, rd_burst_addr_d;
    logic                  read_req_ack_q,  read_req_ack_d;
    logic                  read_finish_q,   read_finish_d;
    logic                  fifo_aclr_q,     fifo_aclr_d;
    logic                  busy_q,          busy_d;
    logic [15:0]           loop_count_q,    loop_count_d;

    // Derived combinational values
    logic                  req_s;
    logic                  stop_s;
    logic [ADDR_BITS-1:0]  slot_addr;
    logic [ADDR_BITS-1:0]  rem;
    logic [ADDR_BITS-1:0]  nxt_a;
    logic [BURST_BITS-1:0] nxt_len;
    logic                  burst_fits;

    assign req_s  = req_sync_q[2];
    assign stop_s = stop_sync_q[2];

    // Shift the asynchronous inputs into their synchroniser chains
    always_comb begin
        req_sync_d  = {req_sync_q[1:0], read_req};
        stop_sync_d = {stop_sync_q[1:0], stop_req};
        len_meta_d  = read_len;
        len_s_d     = len_meta_q;
        idx_meta_d  = read_addr_index;
        idx_s_d     = idx_meta_q;
    end

    // Pick the base address slot; out-of-range indices fall back to slot 0
    always_comb begin
        slot_addr = read_addr_flat[ADDR_BITS-1:0];
        for (int k = 0; k < NUM_ADDR; k++) begin
            if (int'(idx_s_q) == k) begin
                slot_addr = read_addr_flat[k*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Size the next burst and decide whether the FIFO has room for it
    always_comb begin
        rem        = len_lat_q - read_cnt_q;
        nxt_a      = (rem < BURST_SIZE_A) ? rem : BURST_SIZE_A;
        nxt_len    = BURST_BITS'(nxt_a);
        burst_fits = ({1'b0, wrusedw} + 17'(nxt_len)) <= FIFO_DEPTH_W;
    end

    // Frame sequencing: handshake, burst issue, loop wrap and stop handling
    always_comb begin
        state_d         = state_q;
        base_addr_d     = base_addr_q;
        len_lat_d       = len_lat_q;
        read_cnt_d      = read_cnt_q;
        rd_burst_req_d  = rd_burst_req_q;
        rd_burst_len_d  = rd_burst_len_q;
        rd_burst_addr_d = rd_burst_addr_q;
        read_req_ack_d  = read_req_ack_q;
        read_finish_d   = 1'b0;
        fifo_aclr_d     = fifo_aclr_q;
        loop_count_d    = loop_count_q;

        case (state_q)
            S_IDLE: begin
                read_req_ack_d = 1'b0;
                if (req_s) begin
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                if (req_s) begin
                    read_req_ack_d  = 1'b1;
                    fifo_aclr_d     = 1'b1;
                    base_addr_d     = slot_addr;
                    rd_burst_addr_d = slot_addr;
                    len_lat_d       = len_s_q;
                    read_cnt_d      = '0;
                    loop_count_d    = '0;
                end else begin
                    read_req_ack_d = 1'b0;
                    fifo_aclr_d    = 1'b0;
                    if (len_lat_q == '0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (req_s) begin
                    state_d = S_ACK;
                end else if (stop_s) begin
                    state_d = S_END;
                end else if (burst_fits) begin
                    rd_burst_len_d = nxt_len;
                    rd_burst_req_d = 1'b1;
                    state_d        = S_BURST;
                end
            end

            S_BURST: begin
                if (rd_burst_data_valid) begin
                    rd_burst_req_d = 1'b0;
                end
                if (rd_burst_finish) begin
                    rd_burst_req_d  = 1'b0;
                    read_cnt_d      = read_cnt_q + ADDR_BITS'(rd_burst_len_q);
                    rd_burst_addr_d = rd_burst_addr_q + ADDR_BITS'(rd_burst_len_q);
                    state_d         = S_BURST_END;
                end
            end

            S_BURST_END: begin
                if (req_s) begin
                    state_d = S_ACK;
                end else if (stop_s) begin
                    state_d = S_END;
                end else if (read_cnt_q < len_lat_q) begin
                    state_d = S_CHECK;
                end else if (loop_en) begin
                    rd_burst_addr_d = base_addr_q;
                    read_cnt_d      = '0;
                    loop_count_d    = loop_count_q + 16'd1;
                    read_finish_d   = 1'b1;
                    state_d         = S_CHECK;
                end else begin
                    state_d = S_END;
                end
            end

            S_END: begin
                read_finish_d = 1'b1;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            req_sync_q      <= '0;
            stop_sync_q     <= '0;
            len_meta_q      <= '0;
            len_s_q         <= '0;
            idx_meta_q      <= '0;
            idx_s_q         <= '0;
            state_q         <= S_IDLE;
            base_addr_q     <= '0;
            len_lat_q       <= '0;
            read_cnt_q      <= '0;
            rd_burst_req_q  <= 1'b0;
            rd_burst_len_q  <= '0;
            rd_burst_addr_q <= '0;
            read_req_ack_q  <= 1'b0;
            read_finish_q   <= 1'b0;
            fifo_aclr_q     <= 1'b0;
            busy_q          <= 1'b0;
            loop_count_q    <= '0;
        end else begin
            req_sync_q      <= req_sync_d;
            stop_sync_q     <= stop_sync_d;
            len_meta_q      <= len_meta_d;
            len_s_q         <= len_s_d;
            idx_meta_q      <= idx_meta_d;
            idx_s_q         <= idx_s_d;
            state_q         <= state_d;
            base_addr_q     <= base_addr_d;
            len_lat_q       <= len_lat_d;
            read_cnt_q      <= read_cnt_d;
            rd_burst_req_q  <= rd_burst_req_d;
            rd_burst_len_q  <= rd_burst_len_d;
            rd_burst_addr_q <= rd_burst_addr_d;
            read_req_ack_q  <= read_req_ack_d;
            read_finish_q   <= read_finish_d;
            fifo_aclr_q     <= fifo_aclr_d;
            busy_q          <= busy_d;
            loop_count_q    <= loop_count_d;
        end
    end

    assign rd_burst_req  = rd_burst_req_q;
    assign rd_burst_len  = rd_burst_len_q;
    assign rd_burst_addr = rd_burst_addr_q;
    assign read_req_ack  = read_req_ack_q;
    assign read_finish   = read_finish_q;
    assign fifo_aclr     = fifo_aclr_q;
    assign busy          = busy_q;
    assign loop_count    = loop_count_q;

endmodule

// File: tb/tb_frame_fifo_read_multi.sv
// Bench for frame_fifo_read_multi: a table of single frames, then hand-written
// sequences for back-pressure, loop playback with stop, re-request mid-frame
// and reset mid-burst. A small memory-controller model answers each burst and
// checks it against a queue of expected (address, length) pairs.
module tb_frame_fifo_read_multi;

    localparam int ADDR_BITS  = 23;
    localparam int BURST_BITS = 10;
    localparam int FIFO_DEPTH = 256;
    localparam int BURST_SIZE = 128;
    localparam int NUM_ADDR   = 4;
    localparam int IDX_BITS   = 3;

    typedef struct {
        logic [ADDR_BITS-1:0]  addr;
        logic [BURST_BITS-1:0] len;
    } burst_t;

    typedef struct {
        int                   idx;
        int                   len;
        logic [ADDR_BITS-1:0] base;
        int                   nBursts;
        int                   lastLen;
    } frame_vec_t;

    logic                          mem_clk = 1'b0;
    logic                          rst;
    logic                          rd_burst_req;
    logic [BURST_BITS-1:0]         rd_burst_len;
    logic [ADDR_BITS-1:0]          rd_burst_addr;
    logic                          rd_burst_data_valid;
    logic                          rd_burst_finish;
    logic                          read_req;
    logic                          read_req_ack;
    logic                          read_finish;
    logic [NUM_ADDR*ADDR_BITS-1:0] read_addr_flat;
    logic [IDX_BITS-1:0]           read_addr_index;
    logic [ADDR_BITS-1:0]          read_len;
    logic                          loop_en;
    logic                          stop_req;
    logic                          fifo_aclr;
    logic [15:0]                   wrusedw;
    logic                          busy;
    logic [15:0]                   loop_count;

    int checks = 0;
    int errors = 0;
    int burstSeen = 0;
    int finishCount = 0;
    int aclrRise = 0;
    burst_t expQ[$];
    frame_vec_t vecs[5];

    frame_fifo_read_multi #(
        .ADDR_BITS (ADDR_BITS),
        .BURST_BITS(BURST_BITS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BURST_SIZE(BURST_SIZE),
        .NUM_ADDR  (NUM_ADDR),
        .IDX_BITS  (IDX_BITS)
    ) dut (
        .mem_clk            (mem_clk),
        .rst                (rst),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish    (rd_burst_finish),
        .read_req           (read_req),
        .read_req_ack       (read_req_ack),
        .read_finish        (read_finish),
        .read_addr_flat     (read_addr_flat),
        .read_addr_index    (read_addr_index),
        .read_len           (read_len),
        .loop_en            (loop_en),
        .stop_req           (stop_req),
        .fifo_aclr          (fifo_aclr),
        .wrusedw            (wrusedw),
        .busy               (busy),
        .loop_count         (loop_count)
    );

    // Free-running memory clock
    always #5 mem_clk = ~mem_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name, input int cycles);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition not reached within %0d cycles", name, cycles);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd_burst_req"},  32'(rd_burst_req),  32'd0);
        checkOutput({tag, "_rd_burst_len"},  32'(rd_burst_len),  32'd0);
        checkOutput({tag, "_rd_burst_addr"}, 32'(rd_burst_addr), 32'd0);
        checkOutput({tag, "_read_req_ack"},  32'(read_req_ack),  32'd0);
        checkOutput({tag, "_read_finish"},   32'(read_finish),   32'd0);
        checkOutput({tag, "_fifo_aclr"},     32'(fifo_aclr),     32'd0);
        checkOutput({tag, "_busy"},          32'(busy),          32'd0);
        checkOutput({tag, "_loop_count"},    32'(loop_count),    32'd0);
    endtask

    task automatic pushFrame(input logic [ADDR_BITS-1:0] base, input int nBursts, input int lastLen);
        burst_t b;
        for (int k = 0; k < nBursts; k++) begin
            b.addr = base + ADDR_BITS'(k * BURST_SIZE);
            b.len  = (k == nBursts - 1) ? BURST_BITS'(lastLen) : BURST_BITS'(BURST_SIZE);
            expQ.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int idx, input int len, input logic loopMode, input logic checkLat);
        int lat;
        read_addr_index = IDX_BITS'(idx);
        read_len        = ADDR_BITS'(len);
        loop_en         = loopMode;
        read_req        = 1'b1;
        lat = 0;
        do begin
            @(posedge mem_clk); #1;
            lat++;
        end while (read_req_ack !== 1'b1 && lat < 400);
        if (read_req_ack !== 1'b1) timeoutFail("ackWait", lat);
        else if (checkLat) checkOutput("ackLatency", 32'(lat), 32'd5);
        read_req = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        int n = 0;
        while (busy !== 1'b0 && n < maxCycles) begin
            @(posedge mem_clk); #1;
            n++;
        end
        if (busy !== 1'b0) timeoutFail(name, n);
    endtask

    task automatic waitFinishPulse(input string name, input int maxCycles);
        int n = 0;
        do begin
            @(posedge mem_clk); #1;
            n++;
        end while (read_finish !== 1'b1 && n < maxCycles);
        if (read_finish !== 1'b1) timeoutFail(name, n);
    endtask

    // Memory controller model: answers each request and scores it
    initial begin : memCtl
        burst_t e;
        int     beats;
        bit     aborted;
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b0;
        forever begin
            @(posedge mem_clk); #1;
            if (rd_burst_req === 1'b1 && rst === 1'b0) begin
                burstSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL burstUnexpected: got burst addr 0x%0h len %0d, expected none", rd_burst_addr, rd_burst_len);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("burstAddr", 32'(rd_burst_addr), 32'(e.addr));
                    checkOutput("burstLen",  32'(rd_burst_len),  32'(e.len));
                end
                beats   = int'(rd_burst_len);
                aborted = 1'b0;
                for (int i = 0; i <= beats && !aborted; i++) begin
                    rd_burst_data_valid = (i < beats);
                    rd_burst_finish     = (i == beats);
                    @(posedge mem_clk); #1;
                    if (rst) aborted = 1'b1;
                end
                rd_burst_data_valid = 1'b0;
                rd_burst_finish     = 1'b0;
            end
        end
    end

    // Pulse counters and the single-cycle read_finish rule
    initial begin : monitor
        bit prevFinish = 1'b0;
        bit prevAclr   = 1'b0;
        forever begin
            @(posedge mem_clk); #2;
            if (read_finish === 1'b1) begin
                finishCount++;
                checks++;
                if (prevFinish) begin
                    errors++;
                    $display("[TB] FAIL finishWidth: got read_finish high 2 cycles, expected 1");
                end
            end
            prevFinish = (read_finish === 1'b1);
            if (fifo_aclr === 1'b1 && !prevAclr) aclrRise++;
            prevAclr = (fifo_aclr === 1'b1);
        end
    end

    // Safety net against a hung run
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin : main
        int fStart, aStart, bStart;

        vecs[0] = '{idx: 0, len: 256, base: 23'h1000, nBursts: 2, lastLen: 128};
        vecs[1] = '{idx: 2, len: 300, base: 23'h2000, nBursts: 3, lastLen: 44};
        vecs[2] = '{idx: 5, len: 100, base: 23'h1000, nBursts: 1, lastLen: 100};
        vecs[3] = '{idx: 3, len: 0,   base: 23'h3000, nBursts: 0, lastLen: 0};
        vecs[4] = '{idx: 1, len: 128, base: 23'h1800, nBursts: 1, lastLen: 128};

        rst             = 1'b1;
        read_req        = 1'b0;
        stop_req        = 1'b0;
        loop_en         = 1'b0;
        read_len        = '0;
        read_addr_index = '0;
        wrusedw         = 16'd0;
        read_addr_flat  = {23'h3000, 23'h2000, 23'h1800, 23'h1000};

        repeat (3) @(posedge mem_clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(posedge mem_clk); #1;

        $display("[TB] single-frame table");
        for (int v = 0; v < 5; v++) begin
            fStart = finishCount; aStart = aclrRise; bStart = burstSeen;
            pushFrame(vecs[v].base, vecs[v].nBursts, vecs[v].lastLen);
            applyStimulus(vecs[v].idx, vecs[v].len, 1'b0, 1'b1);
            waitIdle($sformatf("vec%0d_idle", v), 2000);
            repeat (2) @(posedge mem_clk);
            #1;
            checkOutput($sformatf("vec%0d_bursts", v),   32'(burstSeen - bStart),   32'(vecs[v].nBursts));
            checkOutput($sformatf("vec%0d_finishes", v), 32'(finishCount - fStart), 32'd1);
            checkOutput($sformatf("vec%0d_aclr", v),     32'(aclrRise - aStart),    32'd1);
            checkOutput($sformatf("vec%0d_queue", v),    32'(expQ.size()),          32'd0);
            checkOutput($sformatf("vec%0d_ack", v),      32'(read_req_ack),         32'd0);
        end

        $display("[TB] back-pressure");
        bStart  = burstSeen;
        wrusedw = 16'd200;
        applyStimulus(0, 128, 1'b0, 1'b1);
        repeat (20) @(posedge mem_clk);
        #1;
        checkOutput("bp_noBurst", 32'(burstSeen - bStart), 32'd0);
        checkOutput("bp_reqLow",  32'(rd_burst_req),       32'd0);
        checkOutput("bp_busy",    32'(busy),               32'd1);
        pushFrame(23'h1000, 1, 128);
        wrusedw = 16'd128;
        @(posedge mem_clk); #1;
        checkOutput("bp_reqNextCycle", 32'(rd_burst_req), 32'd1);
        waitIdle("bp_idle", 1000);
        wrusedw = 16'd0;
        repeat (2) @(posedge mem_clk);
        #1;
        checkOutput("bp_queue", 32'(expQ.size()), 32'd0);

        $display("[TB] loop playback with stop");
        fStart = finishCount; aStart = aclrRise; bStart = burstSeen;
        pushFrame(23'h1000, 1, 128);
        pushFrame(23'h1000, 1, 128);
        pushFrame(23'h1000, 1, 128);
        pushFrame(23'h1000, 1, 128);
        applyStimulus(0, 128, 1'b1, 1'b1);
        for (int w = 1; w <= 3; w++) begin
            waitFinishPulse($sformatf("loop_wrap%0d", w), 500);
            checkOutput($sformatf("loop_count%0d", w), 32'(loop_count), 32'(w));
            checkOutput($sformatf("loop_aclr%0d", w),  32'(fifo_aclr),  32'd0);
        end
        stop_req = 1'b1;
        waitIdle("loop_stopIdle", 1000);
        stop_req = 1'b0;
        repeat (2) @(posedge mem_clk);
        #1;
        checkOutput("loop_bursts",    32'(burstSeen - bStart),   32'd4);
        checkOutput("loop_finishes",  32'(finishCount - fStart), 32'd4);
        checkOutput("loop_aclr",      32'(aclrRise - aStart),    32'd1);
        checkOutput("loop_countHeld", 32'(loop_count),           32'd3);
        checkOutput("loop_queue",     32'(expQ.size()),          32'd0);
        loop_en = 1'b0;

        $display("[TB] re-request mid-frame");
        fStart = finishCount; aStart = aclrRise; bStart = burstSeen;
        pushFrame(23'h1000, 2, 128);
        pushFrame(23'h3000, 2, 128);
        applyStimulus(0, 256, 1'b0, 1'b1);
        begin
            int n = 0;
            while (burstSeen - bStart < 2 && n < 600) begin
                @(posedge mem_clk); #1;
                n++;
            end
            if (burstSeen - bStart < 2) timeoutFail("rereq_secondBurst", n);
        end
        applyStimulus(3, 256, 1'b0, 1'b0);
        waitIdle("rereq_idle", 2000);
        repeat (2) @(posedge mem_clk);
        #1;
        checkOutput("rereq_bursts",   32'(burstSeen - bStart),   32'd4);
        checkOutput("rereq_finishes", 32'(finishCount - fStart), 32'd1);
        checkOutput("rereq_aclr",     32'(aclrRise - aStart),    32'd2);
        checkOutput("rereq_queue",    32'(expQ.size()),          32'd0);

        $display("[TB] reset mid-burst");
        pushFrame(23'h1000, 2, 128);
        applyStimulus(0, 256, 1'b0, 1'b1);
        begin
            int n = 0;
            while (rd_burst_req !== 1'b1 && n < 100) begin
                @(posedge mem_clk); #1;
                n++;
            end
            if (rd_burst_req !== 1'b1) timeoutFail("rstMid_req", n);
        end
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("rstMid");
        repeat (2) @(posedge mem_clk);
        expQ.delete();
        #1;
        rst = 1'b0;
        @(posedge mem_clk); #1;

        fStart = finishCount; bStart = burstSeen;
        pushFrame(23'h1800, 1, 128);
        applyStimulus(1, 128, 1'b0, 1'b1);
        waitIdle("recover_idle", 1000);
        repeat (2) @(posedge mem_clk);
        #1;
        checkOutput("recover_bursts",   32'(burstSeen - bStart),   32'd1);
        checkOutput("recover_finishes", 32'(finishCount - fStart), 32'd1);
        checkOutput("recover_queue",    32'(expQ.size()),          32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
